i2s_slave_transmitter: RTL and testbench

- I2S transmitter that runs as a clock slave: bclk and lrclk come from an external master; the block only shifts serial data out in step with them.
- Accepts stereo PCM frames as valid strobes, the same style of interface the I2S receiver produces.
- Buffers frames in a small FIFO and drives s_data in standard I2S format: MSB-first, one-bclk delay after each lrclk edge.
- Used where the DAC or codec owns the audio clocks, e.g. loopback onto the incoming i2s_bclk/i2s_lrclk.

---
 rtl/i2s_slave_transmitter_if.sv | 43 ++++
 rtl/i2s_slave_transmitter.sv | 262 ++++++++++++++++++++++++++
 tb/tb_i2s_slave_transmitter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_slave_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module      : i2s_slave_transmitter_if
// Description : Bus bundle for the I2S slave transmitter. Carries the external
//               I2S clocks, the run enable, the PCM frame strobes/samples and
//               the serial data plus status outputs.
//               master modport : the side feeding frames and clocks
//               slave  modport : the transmitter itself
// Ports       : audio_en, bclk, lrclk, l_data_en, r_data_en, l_data, r_data
//               (master -> slave); s_data, frame_stb, fifo_level, underflow,
//               overflow (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface i2s_slave_transmitter_if #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4
);
    localparam int C_LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              audio_en;
    logic              bclk;
    logic              lrclk;
    logic              l_data_en;
    logic              r_data_en;
    logic [DATA_W-1:0] l_data;
    logic [DATA_W-1:0] r_data;
    logic              s_data;
    logic              frame_stb;
    logic [C_LVL_W-1:0] fifo_level;
    logic              underflow;
    logic              overflow;

    modport master (
        output audio_en, bclk, lrclk, l_data_en, r_data_en, l_data, r_data,
        input  s_data, frame_stb, fifo_level, underflow, overflow
    );

    modport slave (
        input  audio_en, bclk, lrclk, l_data_en, r_data_en, l_data, r_data,
        output s_data, frame_stb, fifo_level, underflow, overflow
    );
endinterface
`default_nettype wire

// File: rtl/i2s_slave_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : i2s_slave_transmitter
// Description : I2S transmitter running as a clock slave. bclk/lrclk come from
//               an external master and are synchronised into clk. Stereo PCM
//               frames are buffered in a small FIFO and shifted out MSB-first
//               with the standard one-bclk delay after every lrclk edge.
// Ports       : clk   - system clock (>= 8x bclk)
//               reset - asynchronous, active-high reset
//               bus   - i2s_slave_transmitter_if.slave (clocks, frame input,
//                       serial data and status outputs)
// Options     : I2S_TX_UNDERFLOW_REPEAT_EN - when defined, an empty FIFO at a
//               left-slot start resends the last transmitted frame instead of
//               zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_slave_transmitter #(
    parameter int DATA_W      = 24,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             reset,
    i2s_slave_transmitter_if.slave bus
);
    localparam int C_LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int C_PTR_W = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LEFT = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Clock capture
    logic [SYNC_STAGES-1:0] r_bclk_sync;
    logic [SYNC_STAGES-1:0] r_lrclk_sync;
    logic                   r_bclk_d;
    logic                   r_lr_prev;

    // FIFO
    logic [2*DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [C_PTR_W-1:0]  r_wptr;
    logic [C_PTR_W-1:0]  r_rptr;
    logic [C_LVL_W-1:0]  r_level;

    // Datapath
    logic [DATA_W-1:0]   r_l_stage;
    logic [DATA_W-1:0]   r_shifter;
    logic [DATA_W-1:0]   r_hold;
    logic [C_CNT_W-1:0]  r_bit_cnt;
    logic                r_s_data;
    logic                r_frame_stb;
    logic                r_underflow;
    logic                r_overflow;
`ifdef I2S_TX_UNDERFLOW_REPEAT_EN
    logic [2*DATA_W-1:0] r_last;
`endif

    logic                w_bclk_s;
    logic                w_lr_s;
    logic                w_fall;
    logic                w_left_edge;
    logic                w_right_edge;
    logic                w_empty;
    logic                w_full;
    logic                w_push_req;
    logic                w_push;
    logic                w_pop;
    logic                w_left_start;
    logic                w_right_start;
    logic                w_shift;
    logic [2*DATA_W-1:0] w_push_frame;
    logic [2*DATA_W-1:0] w_rd_frame;

    assign w_bclk_s     = r_bclk_sync[SYNC_STAGES-1];
    assign w_lr_s       = r_lrclk_sync[SYNC_STAGES-1];
    assign w_fall       = r_bclk_d & ~w_bclk_s;
    // lrclk is only meaningful at bclk falling edges; compare against the
    // value seen at the previous fall to find slot boundaries.
    assign w_left_edge  = w_fall &  r_lr_prev & ~w_lr_s;
    assign w_right_edge = w_fall & ~r_lr_prev &  w_lr_s;

    assign w_empty      = (r_level == '0);
    assign w_full       = (r_level == C_LVL_W'(FIFO_DEPTH));
    assign w_push_req   = bus.audio_en & bus.r_data_en;
    assign w_push       = w_push_req & ~w_full;
    assign w_pop        = w_left_start & ~w_empty;
    // A left sample arriving with the right one takes priority over staging.
    assign w_push_frame = {(bus.l_data_en ? bus.l_data : r_l_stage), bus.r_data};
    assign w_rd_frame   = r_mem[r_rptr];

    // Synchronisers and edge history run regardless of audio_en so that the
    // first edge after re-enable is classified correctly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bclk_sync  <= '0;
            r_lrclk_sync <= '0;
            r_bclk_d     <= 1'b0;
            r_lr_prev    <= 1'b0;
        end else begin
            r_bclk_sync[0]  <= bus.bclk;
            r_lrclk_sync[0] <= bus.lrclk;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_bclk_sync[i]  <= r_bclk_sync[i-1];
                r_lrclk_sync[i] <= r_lrclk_sync[i-1];
            end
            r_bclk_d <= w_bclk_s;
            if (w_fall) begin
                r_lr_prev <= w_lr_s;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_left_start  = 1'b0;
        w_right_start = 1'b0;
        w_shift       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.audio_en) begin
                    w_state_nxt = ST_WAIT_LEFT;
                end
            end
            ST_WAIT_LEFT: begin
                if (!bus.audio_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_left_edge) begin
                    w_state_nxt  = ST_RUN;
                    w_left_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (!bus.audio_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_left_edge) begin
                    w_left_start = 1'b1;
                end else if (w_right_edge) begin
                    w_right_start = 1'b1;
                end else if (w_fall) begin
                    w_shift = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_frame;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_data    <= 1'b0;
            r_frame_stb <= 1'b0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
            r_l_stage   <= '0;
            r_shifter   <= '0;
            r_hold      <= '0;
            r_bit_cnt   <= '0;
            r_level     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
`ifdef I2S_TX_UNDERFLOW_REPEAT_EN
            r_last      <= '0;
`endif
        end else if (!bus.audio_en) begin
            // Disabled: flush everything and hold the line low.
            r_s_data    <= 1'b0;
            r_frame_stb <= 1'b0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
            r_l_stage   <= '0;
            r_shifter   <= '0;
            r_hold      <= '0;
            r_bit_cnt   <= '0;
            r_level     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
`ifdef I2S_TX_UNDERFLOW_REPEAT_EN
            r_last      <= '0;
`endif
        end else begin
            r_frame_stb <= w_pop;
            if (bus.l_data_en) begin
                r_l_stage <= bus.l_data;
            end
            if (w_push) begin
                r_wptr <= r_wptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + C_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + C_LVL_W'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - C_LVL_W'(1);
            end
            if (w_push_req && w_full) begin
                r_overflow <= 1'b1;
            end

            if (w_left_start) begin
                // The lrclk-edge bit itself is the I2S one-bit delay slot.
                r_bit_cnt <= '0;
                r_s_data  <= 1'b0;
                if (w_pop) begin
                    r_shifter <= w_rd_frame[2*DATA_W-1:DATA_W];
                    r_hold    <= w_rd_frame[DATA_W-1:0];
`ifdef I2S_TX_UNDERFLOW_REPEAT_EN
                    r_last    <= w_rd_frame;
`endif
                end else begin
                    r_underflow <= 1'b1;
`ifdef I2S_TX_UNDERFLOW_REPEAT_EN
                    r_shifter   <= r_last[2*DATA_W-1:DATA_W];
                    r_hold      <= r_last[DATA_W-1:0];
`else
                    r_shifter   <= '0;
                    r_hold      <= '0;
`endif
                end
            end else if (w_right_start) begin
                r_shifter <= r_hold;
                r_bit_cnt <= '0;
                r_s_data  <= 1'b0;
            end else if (w_shift) begin
                if (r_bit_cnt < C_CNT_W'(DATA_W)) begin
                    r_s_data  <= r_shifter[DATA_W-1];
                    r_shifter <= {r_shifter[DATA_W-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + C_CNT_W'(1);
                end else begin
                    r_s_data <= 1'b0;
                end
            end
        end
    end

    assign bus.s_data     = r_s_data;
    assign bus.frame_stb  = r_frame_stb;
    assign bus.fifo_level = r_level;
    assign bus.underflow  = r_underflow;
    assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_i2s_slave_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_slave_transmitter
// Description : Self-checking bench for i2s_slave_transmitter. Drives bclk and
//               lrclk as an external master, keeps a slot-position model of
//               the expected serial stream and checks all outputs at every
//               bclk falling edge, plus literal checks on key words/flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_slave_transmitter;
    localparam int DW    = 24;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    i2s_slave_transmitter_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus();

    i2s_slave_transmitter #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [2*DW-1:0] m_q[$];
    logic [2*DW-1:0] m_last;
    logic [DW-1:0]   m_stage;
    logic [DW-1:0]   m_word;
    logic [DW-1:0]   m_rword;
    logic            m_en, m_run, m_lr_prev, m_s, m_stb, m_uf, m_ovf;
    int              m_pos;

    // Observation helpers for literal checks
    logic [DW-1:0]   cap;
    int              pad_ones;
    int              stb_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("s_data",     64'(bus.s_data),     64'(m_s));
        chk("frame_stb",  64'(bus.frame_stb),  64'(m_stb));
        chk("fifo_level", 64'(bus.fifo_level), 64'(m_q.size()));
        chk("underflow",  64'(bus.underflow),  64'(m_uf));
        chk("overflow",   64'(bus.overflow),   64'(m_ovf));
    endtask

    task automatic model_clear();
        m_q.delete();
        m_last  = '0; m_stage = '0; m_word = '0; m_rword = '0;
        m_run   = 1'b0; m_s = 1'b0; m_stb = 1'b0; m_uf = 1'b0; m_ovf = 1'b0;
        m_pos   = 0;
    endtask

    // Expected serial bit at a bclk fall: position 0 is the lrclk-edge delay
    // slot, positions 1..DW carry the word MSB-first, later positions are 0.
    task automatic model_fall(input logic lr);
        logic [2*DW-1:0] f;
        if (m_en) begin
            if (m_lr_prev && !lr) begin
                m_run = 1'b1;
                m_pos = 0;
                if (m_q.size() > 0) begin
                    f      = m_q.pop_front();
                    m_stb  = 1'b1;
                    m_last = f;
                end else begin
`ifdef I2S_TX_UNDERFLOW_REPEAT_EN
                    f = m_last;
`else
                    f = '0;
`endif
                    m_uf = 1'b1;
                end
                m_word  = f[2*DW-1:DW];
                m_rword = f[DW-1:0];
            end else if (m_run && !m_lr_prev && lr) begin
                m_pos  = 0;
                m_word = m_rword;
            end else if (m_run) begin
                m_pos++;
            end
            m_s = (m_run && m_pos >= 1 && m_pos <= DW) ? m_word[DW-m_pos] : 1'b0;
        end else begin
            m_s = 1'b0;
        end
        m_lr_prev = lr;
    endtask

    task automatic bclk_cycle(input logic lr);
        @(posedge clk); #1;
        bus.bclk  = 1'b0;
        bus.lrclk = lr;
        model_fall(lr);
        repeat (3) @(posedge clk);
        #2;
        compare();
        if (bus.frame_stb) stb_cnt++;
        if (m_run && m_pos >= 1 && m_pos <= DW) cap = {cap[DW-2:0], bus.s_data};
        if (m_run && m_pos > DW && bus.s_data) pad_ones++;
        m_stb = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.bclk = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic run_bits(input logic lr, input int n);
        cap      = '0;
        pad_ones = 0;
        for (int i = 0; i < n; i++) bclk_cycle(lr);
    endtask

    // mode 0: left then right strobe, 1: both strobes together, 2: right only
    task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r, input int mode);
        #1;
        if (mode == 0) begin
            bus.l_data = l; bus.l_data_en = 1'b1;
            @(posedge clk); #1;
            bus.l_data_en = 1'b0;
        end
        if (mode == 1) begin
            bus.l_data = l; bus.l_data_en = 1'b1;
        end
        bus.r_data = r; bus.r_data_en = 1'b1;
        @(posedge clk); #1;
        bus.l_data_en = 1'b0; bus.r_data_en = 1'b0;
        if (m_en) begin
            if (mode != 2) m_stage = l;
            if (m_q.size() < DEPTH) m_q.push_back({m_stage, r});
            else m_ovf = 1'b1;
        end
        #1 compare();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.audio_en = 1'b0; bus.bclk = 1'b1; bus.lrclk = 1'b1;
        bus.l_data_en = 1'b0; bus.r_data_en = 1'b0;
        bus.l_data = '0; bus.r_data = '0;
        m_en = 1'b0; m_lr_prev = 1'b0;
        model_clear();
        cap = '0; pad_ones = 0; stb_cnt = 0;

        // Reset state
        repeat (3) @(posedge clk); #2;
        compare();
        #1 reset = 1'b0;
        @(posedge clk); #1;
        bus.audio_en = 1'b1; m_en = 1'b1;
        repeat (3) @(posedge clk); #2;
        compare();

        // Single frame, standard 32-bclk slots
        push(24'hA5A5A5, 24'h5A5A5A, 0);
        chk("level_after_push", 64'(bus.fifo_level), 64'd1);
        run_bits(1'b1, 2);
        stb_cnt = 0;
        run_bits(1'b0, 32);
        chk("left_word_A5",  64'(cap), 64'hA5A5A5);
        chk("stb_once",      64'(stb_cnt), 64'd1);
        chk("level_popped",  64'(bus.fifo_level), 64'd0);
        chk("left_pad_zero", 64'(pad_ones), 64'd0);
        run_bits(1'b1, 32);
        chk("right_word_5A", 64'(cap), 64'h5A5A5A);

        // Underflow
        run_bits(1'b0, 32);
`ifndef I2S_TX_UNDERFLOW_REPEAT_EN
        chk("uf_zero_word", 64'(cap), 64'h0);
`endif
        chk("uf_set", 64'(bus.underflow), 64'd1);
        run_bits(1'b1, 32);

        // Overflow: five pushes into four entries with bclk stopped
        for (int k = 1; k <= 5; k++)
            push(24'h100000 * k + 24'h000011 * k, 24'h0A0000 * k + 24'h000022 * k, 0);
        chk("ovf_level", 64'(bus.fifo_level), 64'd4);
        chk("ovf_flag",  64'(bus.overflow), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            logic [DW-1:0] exp_l;
            exp_l = 24'h100000 * k + 24'h000011 * k;
            run_bits(1'b0, 32);
            chk("ovf_frame_left", 64'(cap), 64'(exp_l));
            run_bits(1'b1, 32);
        end
        chk("ovf_drained", 64'(bus.fifo_level), 64'd0);

        // Simultaneous strobes override the staged left sample
        push(24'h123456, 24'h654321, 1);
        run_bits(1'b0, 32);
        chk("sim_left",  64'(cap), 64'h123456);
        run_bits(1'b1, 32);
        chk("sim_right", 64'(cap), 64'h654321);

        // Right-only push reuses l_stage; odd slot lengths
        push(24'hABCDEF, 24'h13579B, 0);
        push(24'h000000, 24'h2468AC, 2);
        run_bits(1'b0, 24);
        chk("short_slot_lsb_dropped", 64'(cap), 64'h55E6F7);
        run_bits(1'b1, 20);
        run_bits(1'b0, 40);
        chk("reuse_stage_left", 64'(cap), 64'hABCDEF);
        chk("long_slot_pad",    64'(pad_ones), 64'd0);
        run_bits(1'b1, 32);
        chk("reuse_stage_right", 64'(cap), 64'h2468AC);

        // Disable mid left slot, re-enable mid right slot
        push(24'hFFFFFF, 24'hFFFFFF, 0);
        push(24'hFFFFFF, 24'hFFFFFF, 0);
        run_bits(1'b0, 10);
        @(posedge clk); #1;
        bus.bclk = 1'b0; bus.lrclk = 1'b0; model_fall(1'b0);
        repeat (3) @(posedge clk); #2;
        compare();
        m_stb = 1'b0;
        bus.audio_en = 1'b0;
        @(posedge clk); #2;
        m_en = 1'b0; model_clear();
        chk("dis_sdata", 64'(bus.s_data), 64'd0);
        chk("dis_level", 64'(bus.fifo_level), 64'd0);
        chk("dis_flags", 64'({bus.underflow, bus.overflow}), 64'd0);
        compare();
        repeat (4) @(posedge clk); #1 bus.bclk = 1'b1;
        repeat (8) @(posedge clk);
        run_bits(1'b0, 21);
        run_bits(1'b1, 5);
        #1 bus.audio_en = 1'b1; m_en = 1'b1;
        run_bits(1'b1, 27);
        push(24'hC0FFEE, 24'hBADA55, 0);
        run_bits(1'b0, 32);
        chk("reen_left", 64'(cap), 64'hC0FFEE);
        run_bits(1'b1, 32);
        chk("reen_right", 64'(cap), 64'hBADA55);

        // Asynchronous reset mid right slot with frames queued
        push(24'h111111, 24'h222222, 0);
        push(24'h333333, 24'h444444, 0);
        push(24'h555555, 24'h666666, 0);
        run_bits(1'b0, 32);
        run_bits(1'b1, 10);
        #3 reset = 1'b1;
        #1;
        chk("rst_sdata", 64'(bus.s_data), 64'd0);
        chk("rst_level", 64'(bus.fifo_level), 64'd0);
        model_clear(); m_lr_prev = 1'b0;
        compare();
        @(posedge clk); #1 reset = 1'b0;
        run_bits(1'b1, 22);
        run_bits(1'b0, 32);
        chk("post_rst_no_stale", 64'(cap), 64'h0);
        chk("post_rst_uf", 64'(bus.underflow), 64'd1);
        run_bits(1'b1, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
